chunk_processor: RTL and testbench
==================================

Name: chunk_processor

Overview:
- Block-based DSP core between the double-buffered I2S receive RAM and the transmit RAM.
- On each chunk trigger it reads one full 64-sample buffer from the input RAM in address order.
- It applies a fixed-point gain with saturation to each sample.
- It writes each result to the same address of the output RAM.
- It runs entirely in the system clock domain; the trigger is already synchronised to clk upstream.

Parameters:
- SAMPLE_W, 24, signed sample width (input and output).
- PTR_W, 6, buffer address width.
- BUF_DEPTH, 64, samples per chunk; must equal 2**PTR_W.
- GAIN, 1, signed multiplier, 16-bit signed range.
- GAIN_SHIFT, 0, arithmetic right shift applied after the multiply, 0..15.
- READ_LATENCY, 1, input RAM read latency in clk cycles (synchronous read).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- chunk_pulse  in  1  chunk-ready trigger; its rising edge starts processing.
- input_buff_ptr  out  PTR_W  read address to input RAM.
- input_buff_sample  in  SAMPLE_W  signed read data; valid READ_LATENCY cycles after address.
- output_buff_ptr  out  PTR_W  write address to output RAM.
- output_buff_sample  out  SAMPLE_W  signed processed sample.
- output_buff_write_pulse  out  1  one-cycle write enable per sample.
- busy  out  1  high while a chunk is in flight.
- overrun  out  1  one-cycle pulse when a trigger arrives while busy.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low; clock port is clk, reset port is rst_n.
- Reset clears all outputs, pointers and state to 0 and puts the FSM in IDLE. The trigger-edge register also resets to 0, so chunk_pulse held high across reset release triggers exactly once.
- Trigger: rising edge detected as chunk_pulse=1 with previous-cycle value 0. A pulse of any length starts exactly one chunk.
- FSM states:
  - IDLE: input_buff_ptr holds 0; busy=0. On a trigger edge, go to RUN.
  - RUN: busy=1. Read addresses advance by one per cycle, starting from 0.
  - DRAIN: entered after address BUF_DEPTH-1 is issued. Waits for the last READ_LATENCY+1 pipeline stages to write, then returns to IDLE.
- Timing. Let cycle 0 be the first cycle after the edge that samples the trigger:
  - input_buff_ptr = k during cycle k, for k = 0..BUF_DEPTH-1.
  - Data for k is registered at the end of cycle k+READ_LATENCY.
  - output_buff_write_pulse=1 with output_buff_ptr=k and output_buff_sample=f(sample k) during cycle k+READ_LATENCY+1.
  - Writes are consecutive, with no gaps, in address order 0..63.
  - busy falls in the cycle after the last write (cycle 66 with defaults).
- Arithmetic:
  - p = input_sample * GAIN, full-precision signed, SAMPLE_W+16 bits.
  - q = p >>> GAIN_SHIFT.
  - Saturate q to [-2**(SAMPLE_W-1), 2**(SAMPLE_W-1)-1]. With defaults the result is identity.
- Address wrap: the read pointer stops at BUF_DEPTH-1; it never wraps to 0 within a chunk.
- Trigger while busy: ignored (the current chunk completes unchanged); overrun pulses for one cycle.
- A trigger edge in the same cycle busy falls is accepted: the next chunk starts with no lost cycle.
- Reset mid-chunk: stops immediately and write_pulse drops at once. No further writes until a new trigger edge after reset release.
- output_buff_sample and output_buff_ptr are don't-care when write_pulse=0, but they hold their last values (no X).

Decomposition:
- Package chunk_proc_pkg holds:
  - SAMPLE_W, PTR_W and BUF_DEPTH constants.
  - The SAMPLE_MAX/SAMPLE_MIN saturation limits.
  - The FSM state enum (IDLE, RUN, DRAIN).
- One sub-module, sample_gain_sat: combinational multiply, shift and saturate, parameterised by GAIN/GAIN_SHIFT. The processor registers its output.

Test Plan:
- Identity: RAM model with latency 1 holding sample[k] = k*1000-32000, then a single 1-cycle chunk_pulse → exactly 64 write pulses in cycles 2..65, ptr k, data equal to input. busy=0 at cycle 66.
- Gain/saturation: GAIN=4, SHIFT=1 with inputs 8388607, -8388608, 100, -3 → outputs 8388607, -8388608, 200, -6.
- Long trigger and overrun: chunk_pulse held high for 10 cycles → one chunk only. A second edge at cycle 20 → overrun=1 for one cycle, still exactly 64 writes. An edge at cycle 66 → a second chunk starts at cycle 67.
- Reset mid-chunk: rst_n low at cycle 30 → write_pulse=0 and busy=0 immediately, ptrs 0. After release, no writes until a new edge; the next chunk writes all 64 from address 0.
- Latency parameter: READ_LATENCY=2 → the write for address k occurs in cycle k+3, and busy falls at cycle 67.
- Trigger during reset: chunk_pulse high while rst_n releases → exactly one chunk processed.

Source files
------------

// File: rtl/chunk_proc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : chunk_proc_pkg                                                |
// | Desc     : Shared widths, saturation limits and FSM states.              |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package chunk_proc_pkg;

  localparam int SAMPLE_W  = 24;
  localparam int PTR_W     = 6;
  localparam int BUF_DEPTH = 64;

  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sample_gain_sat.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sample_gain_sat                                               |
// | Desc     : Combinational signed gain, arithmetic shift and saturation.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module sample_gain_sat #(
  parameter int SAMPLE_W   = chunk_proc_pkg::SAMPLE_W,
  parameter int GAIN       = 1,
  parameter int GAIN_SHIFT = 0
) (
  input  logic signed [SAMPLE_W-1:0] i_sample,
  output logic signed [SAMPLE_W-1:0] o_sample
);

  localparam int P_W = SAMPLE_W + 16;
  localparam logic signed [15:0]    c_gain = 16'(GAIN);
  // Output limits sign-extended to product width; min is the bitwise inverse of max.
  localparam logic signed [P_W-1:0] c_max  = {{(P_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [P_W-1:0] c_min  = ~c_max;

  logic signed [P_W-1:0] w_a;
  logic signed [P_W-1:0] w_g;
  logic signed [P_W-1:0] w_prod;
  logic signed [P_W-1:0] w_shift;

  assign w_a     = {{16{i_sample[SAMPLE_W-1]}}, i_sample};
  assign w_g     = {{SAMPLE_W{c_gain[15]}}, c_gain};
  assign w_prod  = w_a * w_g;
  assign w_shift = w_prod >>> GAIN_SHIFT;

  always_comb begin
    o_sample = w_shift[SAMPLE_W-1:0];
    if (w_shift > c_max) begin
      o_sample = c_max[SAMPLE_W-1:0];
    end else if (w_shift < c_min) begin
      o_sample = c_min[SAMPLE_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/chunk_processor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : chunk_processor                                               |
// | Desc     : Reads one input buffer per trigger, applies gain, writes out. |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module chunk_processor
  import chunk_proc_pkg::state_t, chunk_proc_pkg::IDLE, chunk_proc_pkg::RUN, chunk_proc_pkg::DRAIN;
#(
  parameter int SAMPLE_W     = chunk_proc_pkg::SAMPLE_W,
  parameter int PTR_W        = chunk_proc_pkg::PTR_W,
  parameter int BUF_DEPTH    = chunk_proc_pkg::BUF_DEPTH,
  parameter int GAIN         = 1,
  parameter int GAIN_SHIFT   = 0,
  parameter int READ_LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       chunk_pulse,
  output logic [PTR_W-1:0]           input_buff_ptr,
  input  logic signed [SAMPLE_W-1:0] input_buff_sample,
  output logic [PTR_W-1:0]           output_buff_ptr,
  output logic signed [SAMPLE_W-1:0] output_buff_sample,
  output logic                       output_buff_write_pulse,
  output logic                       busy,
  output logic                       overrun
);

  localparam int c_cnt_w = $clog2(READ_LATENCY + 2);

  state_t                            r_state, w_state_nxt;
  logic [PTR_W-1:0]                  r_ptr, w_ptr_nxt;
  logic [c_cnt_w-1:0]                r_drain, w_drain_nxt;
  logic                              r_pulse_d;
  logic                              r_overrun;
  logic                              w_edge;
  logic                              w_run;
  logic [READ_LATENCY-1:0]           r_vld_pipe;
  logic [READ_LATENCY-1:0][PTR_W-1:0] r_ptr_pipe;
  logic                              r_we;
  logic [PTR_W-1:0]                  r_optr;
  logic signed [SAMPLE_W-1:0]        r_osample;
  logic signed [SAMPLE_W-1:0]        w_gain;

  assign w_edge = chunk_pulse & ~r_pulse_d;
  assign w_run  = (r_state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_drain <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_drain <= w_drain_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_drain_nxt = r_drain;
    case (r_state)
      IDLE: begin
        w_ptr_nxt = '0;
        if (w_edge) w_state_nxt = RUN;
      end
      RUN: begin
        // Pointer parks on the last address; it never wraps inside a chunk.
        if (r_ptr == PTR_W'(BUF_DEPTH - 1)) begin
          w_state_nxt = DRAIN;
          w_drain_nxt = '0;
        end else begin
          w_ptr_nxt = r_ptr + 1'b1;
        end
      end
      DRAIN: begin
        if (r_drain == c_cnt_w'(READ_LATENCY)) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = '0;
        end else begin
          w_drain_nxt = r_drain + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Address/valid delay line matching the RAM read latency.
  generate
    if (READ_LATENCY > 1) begin : g_pipe_deep
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld_pipe <= '0;
          r_ptr_pipe <= '0;
        end else begin
          r_vld_pipe <= {r_vld_pipe[READ_LATENCY-2:0], w_run};
          r_ptr_pipe <= {r_ptr_pipe[READ_LATENCY-2:0], r_ptr};
        end
      end
    end else begin : g_pipe_one
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld_pipe <= '0;
          r_ptr_pipe <= '0;
        end else begin
          r_vld_pipe <= w_run;
          r_ptr_pipe <= r_ptr;
        end
      end
    end
  endgenerate

  sample_gain_sat #(
    .SAMPLE_W  (SAMPLE_W),
    .GAIN      (GAIN),
    .GAIN_SHIFT(GAIN_SHIFT)
  ) u_gain (
    .i_sample(input_buff_sample),
    .o_sample(w_gain)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pulse_d <= 1'b0;
      r_overrun <= 1'b0;
      r_we      <= 1'b0;
      r_optr    <= '0;
      r_osample <= '0;
    end else begin
      r_pulse_d <= chunk_pulse;
      r_overrun <= w_edge && (r_state != IDLE);
      r_we      <= r_vld_pipe[READ_LATENCY-1];
      if (r_vld_pipe[READ_LATENCY-1]) begin
        r_optr    <= r_ptr_pipe[READ_LATENCY-1];
        r_osample <= w_gain;
      end
    end
  end

  assign input_buff_ptr          = r_ptr;
  assign output_buff_ptr         = r_optr;
  assign output_buff_sample      = r_osample;
  assign output_buff_write_pulse = r_we;
  assign busy                    = (r_state != IDLE);
  assign overrun                 = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_chunk_processor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_chunk_processor                                            |
// | Desc     : Directed bench: identity, gain/saturation and latency-2 DUTs. |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_chunk_processor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic chunk_pulse = 1'b0;

  always #5 clk = ~clk;

  // Instance 0: defaults, 1: GAIN=4 SHIFT=1, 2: READ_LATENCY=2.
  logic [5:0]         ip [3];
  logic [5:0]         op [3];
  logic signed [23:0] rd [3];
  logic signed [23:0] os [3];
  logic               we [3];
  logic               bsy[3];
  logic               ovr[3];

  logic signed [23:0] mem [64];
  logic signed [23:0] rd2a;
  longint             exp_d [3][64];

  int n_chk  = 0;
  int n_fail = 0;

  always @(posedge clk) begin
    rd[0] <= mem[ip[0]];
    rd[1] <= mem[ip[1]];
    rd2a  <= mem[ip[2]];
    rd[2] <= rd2a;
  end

  chunk_processor u_dut0 (
    .clk(clk), .rst_n(rst_n), .chunk_pulse(chunk_pulse),
    .input_buff_ptr(ip[0]), .input_buff_sample(rd[0]),
    .output_buff_ptr(op[0]), .output_buff_sample(os[0]),
    .output_buff_write_pulse(we[0]), .busy(bsy[0]), .overrun(ovr[0])
  );

  chunk_processor #(.GAIN(4), .GAIN_SHIFT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .chunk_pulse(chunk_pulse),
    .input_buff_ptr(ip[1]), .input_buff_sample(rd[1]),
    .output_buff_ptr(op[1]), .output_buff_sample(os[1]),
    .output_buff_write_pulse(we[1]), .busy(bsy[1]), .overrun(ovr[1])
  );

  chunk_processor #(.READ_LATENCY(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .chunk_pulse(chunk_pulse),
    .input_buff_ptr(ip[2]), .input_buff_sample(rd[2]),
    .output_buff_ptr(op[2]), .output_buff_sample(os[2]),
    .output_buff_write_pulse(we[2]), .busy(bsy[2]), .overrun(ovr[2])
  );

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Walk cycles -1..ncyc relative to the trigger; cycle 0 follows the sampling edge.
  task automatic walk(input int ncyc, input int len, input int e2, input int e3,
                      input bit lat2, input int exp_ovr, input bit rel);
    int novr [3];
    for (int i = 0; i < 3; i++) novr[i] = 0;
    for (int c = -1; c <= ncyc; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (i != 2 || lat2) begin
          int lat, k, s, ip_exp;
          bit ew, eb, er;
          lat = (i == 2) ? 2 : 1;
          ew = 1'b0; eb = 1'b0; er = 1'b0; k = 0; ip_exp = 0;
          for (int j = 0; j < 2; j++) begin
            s = (j == 0) ? 0 : ((e3 >= 0) ? e3 + 1 : -1000);
            if (c - s - lat - 1 >= 0 && c - s - lat - 1 <= 63) begin
              ew = 1'b1;
              k  = c - s - lat - 1;
            end
            if (c - s >= 0 && c - s <= 64 + lat) eb = 1'b1;
            if (c - s >= 0 && c - s <= 63) begin
              er     = 1'b1;
              ip_exp = c - s;
            end
          end
          check_val($sformatf("u%0d we c%0d", i, c), longint'(we[i]), longint'(ew));
          if (ew) begin
            check_val($sformatf("u%0d optr c%0d", i, c), longint'(op[i]), longint'(k));
            check_val($sformatf("u%0d odata c%0d", i, c), longint'(os[i]), exp_d[i][k]);
          end
          check_val($sformatf("u%0d busy c%0d", i, c), longint'(bsy[i]), longint'(eb));
          if (er || !eb)
            check_val($sformatf("u%0d iptr c%0d", i, c), longint'(ip[i]), longint'(ip_exp));
          novr[i] += int'(ovr[i]);
        end
      end
      chunk_pulse = (c < len - 1) || (c == e2) || (c == e3);
      if (rel) rst_n = 1'b1;
    end
    for (int i = 0; i < 3; i++)
      if (i != 2 || lat2)
        check_val($sformatf("u%0d overrun count", i), longint'(novr[i]), longint'(exp_ovr));
  endtask

  task automatic check_idle(input string tag);
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("%s u%0d we", tag, i), longint'(we[i]), 0);
      check_val($sformatf("%s u%0d busy", tag, i), longint'(bsy[i]), 0);
      check_val($sformatf("%s u%0d iptr", tag, i), longint'(ip[i]), 0);
      check_val($sformatf("%s u%0d optr", tag, i), longint'(op[i]), 0);
      check_val($sformatf("%s u%0d ovr", tag, i), longint'(ovr[i]), 0);
    end
  endtask

  initial begin
    for (int k = 0; k < 64; k++) begin
      mem[k]      = 24'(k * 1000 - 32000);
      exp_d[1][k] = longint'(2 * (k * 1000 - 32000));
    end
    mem[0] = 24'sd8388607;
    mem[1] = -24'sd8388608;
    mem[2] = 24'sd100;
    mem[3] = -24'sd3;
    exp_d[1][0] = 8388607;
    exp_d[1][1] = -8388608;
    exp_d[1][2] = 200;
    exp_d[1][3] = -6;
    for (int k = 0; k < 64; k++) begin
      exp_d[0][k] = longint'(mem[k]);
      exp_d[2][k] = longint'(mem[k]);
    end

    // Reset state
    repeat (3) @(negedge clk);
    check_idle("reset");
    for (int i = 0; i < 3; i++)
      check_val($sformatf("reset u%0d odata", i), longint'(os[i]), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single short trigger on all three variants
    walk(70, 1, -99, -99, 1'b1, 0, 1'b0);

    // Long trigger, edge while busy, edge as busy falls
    walk(136, 10, 20, 66, 1'b0, 1, 1'b0);

    // Reset in the middle of a chunk
    walk(29, 1, -99, -99, 1'b1, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle("midrst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        check_val($sformatf("post-rst u%0d we n%0d", i, n), longint'(we[i]), 0);
        check_val($sformatf("post-rst u%0d busy n%0d", i, n), longint'(bsy[i]), 0);
      end
    end
    walk(70, 1, -99, -99, 1'b1, 0, 1'b0);

    // Trigger held high while reset releases
    @(negedge clk);
    rst_n = 1'b0;
    chunk_pulse = 1'b1;
    @(negedge clk);
    walk(71, 5, -99, -99, 1'b1, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
